// File: rtl/vin_pkg.sv
// Shared constants for the FPD-Link video-input supervisor and its SERDES wrapper.
package vin_pkg;

  localparam logic [1:0] S_RST   = 2'd0;
  localparam logic [1:0] S_SYNC  = 2'd1;
  localparam logic [1:0] S_TRAIN = 2'd2;
  localparam logic [1:0] S_LOCK  = 2'd3;

  localparam int CW_DEF         = 16;
  localparam int RST_CYCLES_DEF = 64;
  localparam int TIMEOUT_DEF    = 1048576;

  function automatic logic out_of_tol(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] tol);
    logic [31:0] d;
    d = (a > b) ? (a - b) : (b - a);
    return d > tol;
  endfunction

endpackage

// File: rtl/vin_timing_meas.sv
// Edge detection plus line/frame/active/timeout counters on the raw deserialiser timing.
module vin_timing_meas
  import vin_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_hsync,
  input  logic          i_vsync,
  input  logic          i_de,
  output logic          o_hs_rise,
  output logic          o_vs_rise,
  output logic [CW-1:0] o_hcnt,
  output logic [CW-1:0] o_lcnt,
  output logic [CW-1:0] o_a_first,
  output logic          o_hcnt_sat,
  output logic          o_to_fault
);

  localparam int              TW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CMAX    = '1;
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT - 1);

  logic          r_hs, r_vs;
  logic [CW-1:0] r_hcnt, r_lcnt, r_acnt, r_a_first;
  logic [TW-1:0] r_tocnt;
  logic          r_de_seen, r_a_taken;
  logic          w_hs_rise, w_vs_rise;

  assign w_hs_rise  = i_hsync & ~r_hs;
  assign w_vs_rise  = i_vsync & ~r_vs;
  assign o_hs_rise  = w_hs_rise;
  assign o_vs_rise  = w_vs_rise;
  assign o_hcnt     = r_hcnt;
  assign o_lcnt     = r_lcnt;
  assign o_a_first  = r_a_first;
  assign o_hcnt_sat = (r_hcnt == CMAX);
  assign o_to_fault = (r_tocnt == TO_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_hs      <= 1'b0;
      r_vs      <= 1'b0;
      r_hcnt    <= '0;
      r_lcnt    <= '0;
      r_acnt    <= '0;
      r_a_first <= '0;
      r_tocnt   <= '0;
      r_de_seen <= 1'b0;
      r_a_taken <= 1'b0;
    end else begin
      r_hs <= i_hsync;
      r_vs <= i_vsync;

      if (w_hs_rise)           r_hcnt <= CW'(1);
      else if (r_hcnt != CMAX) r_hcnt <= r_hcnt + 1'b1;

      if (w_vs_rise)                        r_lcnt <= '0;
      else if (w_hs_rise && r_lcnt != CMAX) r_lcnt <= r_lcnt + 1'b1;

      if (w_hs_rise)                   r_acnt <= '0;
      else if (i_de && r_acnt != CMAX) r_acnt <= r_acnt + 1'b1;

      // Saturates so a dead link keeps reporting the fault until hsync returns.
      if (w_hs_rise)               r_tocnt <= '0;
      else if (r_tocnt != TO_LAST) r_tocnt <= r_tocnt + 1'b1;

      if (w_vs_rise) begin
        r_de_seen <= 1'b0;
        r_a_taken <= 1'b0;
      end else begin
        if (i_de) r_de_seen <= 1'b1;
        if (w_hs_rise && r_de_seen && !r_a_taken) begin
          r_a_first <= r_acnt;
          r_a_taken <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vin_link_supervisor.sv
// FPD-Link input supervisor: SERDES reset sequencing, timing qualification and lock declaration.
module vin_link_supervisor
  import vin_pkg::*;
#(
  parameter int RST_CYCLES  = RST_CYCLES_DEF,
  parameter int LOCK_FRAMES = 5,
  parameter int H_TOL       = 2,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int CW          = CW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          de,
  output logic          serdes_rst,
  output logic          locked,
  output logic          frame_en,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] h_active,
  output logic [7:0]    retry_cnt
);

  localparam int RCW = $clog2(RST_CYCLES + 1);

  logic          w_hs_rise, w_vs_rise, w_hcnt_sat, w_to_fault;
  logic [CW-1:0] w_hcnt, w_lcnt, w_a_first;

  vin_timing_meas #(.CW(CW), .TIMEOUT(TIMEOUT)) u_meas (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_hsync   (hsync),
    .i_vsync   (vsync),
    .i_de      (de),
    .o_hs_rise (w_hs_rise),
    .o_vs_rise (w_vs_rise),
    .o_hcnt    (w_hcnt),
    .o_lcnt    (w_lcnt),
    .o_a_first (w_a_first),
    .o_hcnt_sat(w_hcnt_sat),
    .o_to_fault(w_to_fault)
  );

  logic [1:0]     r_state;
  logic [RCW-1:0] r_rcnt;
  logic [3:0]     r_fo;
  logic [CW-1:0]  r_vref, r_href, r_htot, r_vtot, r_hact;
  logic           r_href_v, r_locked, r_fen;
  logic [7:0]     r_retry;

  logic       w_line_bad, w_frame_bad, w_frame_match, w_go_rst;
  logic [3:0] w_fo_next;

  assign serdes_rst = (r_state == S_RST);
  assign locked     = r_locked;
  assign frame_en   = r_fen;
  assign h_total    = r_htot;
  assign v_total    = r_vtot;
  assign h_active   = r_hact;
  assign retry_cnt  = r_retry;

  // A line fault and a frame fault share one exit, so a line fault on a shared edge wins.
  always_comb begin
    w_line_bad    = w_hs_rise && r_href_v &&
                    out_of_tol(32'(w_hcnt), 32'(r_href), 32'(H_TOL));
    w_frame_bad   = w_vs_rise && (w_lcnt != r_vtot);
    w_frame_match = (r_fo != 4'd0) && (w_lcnt == r_vref);
    w_fo_next     = w_frame_match ? (r_fo + 4'd1) : 4'd1;
    w_go_rst      = 1'b0;
    case (r_state)
      S_SYNC:  w_go_rst = w_to_fault || w_hcnt_sat;
      S_TRAIN: w_go_rst = w_to_fault || w_hcnt_sat || w_line_bad;
      S_LOCK:  w_go_rst = w_to_fault || w_hcnt_sat || w_line_bad || w_frame_bad;
      default: w_go_rst = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= S_RST;
      r_rcnt   <= '0;
      r_fo     <= '0;
      r_vref   <= '0;
      r_href   <= '0;
      r_href_v <= 1'b0;
      r_locked <= 1'b0;
      r_fen    <= 1'b0;
      r_htot   <= '0;
      r_vtot   <= '0;
      r_hact   <= '0;
      r_retry  <= '0;
    end else if (w_go_rst) begin
      r_state  <= S_RST;
      r_rcnt   <= '0;
      r_locked <= 1'b0;
      r_fen    <= 1'b0;
      if (r_retry != 8'hFF) r_retry <= r_retry + 8'd1;
    end else begin
      case (r_state)
        S_RST: begin
          if (r_rcnt == RCW'(RST_CYCLES - 1)) begin
            r_state <= S_SYNC;
            r_rcnt  <= '0;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
        S_SYNC: begin
          if (w_vs_rise) begin
            r_state  <= S_TRAIN;
            r_fo     <= '0;
            r_href_v <= 1'b0;
          end
        end
        S_TRAIN: begin
          if (w_hs_rise && !r_href_v) begin
            r_href   <= w_hcnt;
            r_href_v <= 1'b1;
          end
          if (w_vs_rise) begin
            r_fo <= w_fo_next;
            if (!w_frame_match) r_vref <= w_lcnt;
            if (r_href_v && w_fo_next == 4'(LOCK_FRAMES)) begin
              r_state  <= S_LOCK;
              r_locked <= 1'b1;
              r_fen    <= 1'b1;
              r_htot   <= r_href;
              r_vtot   <= w_lcnt;
              r_hact   <= w_a_first;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vin_link_supervisor.sv
// Scoreboard bench: expected output transitions are queued ahead of stimulus and popped by a monitor.
module tb_vin_link_supervisor;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          hsync = 1'b0, vsync = 1'b0, de = 1'b0;
  logic          serdes_rst, locked, frame_en;
  logic [CW-1:0] h_total, v_total, h_active;
  logic [7:0]    retry_cnt;

  vin_link_supervisor #(
    .RST_CYCLES(64), .LOCK_FRAMES(5), .H_TOL(2), .TIMEOUT(4096), .CW(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .hsync(hsync), .vsync(vsync), .de(de),
    .serdes_rst(serdes_rst), .locked(locked), .frame_en(frame_en),
    .h_total(h_total), .v_total(v_total), .h_active(h_active),
    .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   id;
    logic sr;
    logic lk;
    logic fe;
    int   ht;
    int   vt;
    int   ha;
    int   rc;
    int   dur;
    int   nvs;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_exp = 0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0, last_cyc = 0, vs_cnt = 0, vs_base = 0;
  logic prev_vs = 1'b0, prev_sr = 1'b0, prev_lk = 1'b0;
  logic rst_edge;

  task automatic chk(input int id, input string what, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL evt%0d %s got %0d want %0d", id, what, got, want);
    end
  endtask

  task automatic push_exp(input logic sr, input logic lk, input logic fe, input int ht,
                          input int vt, input int ha, input int rc, input int dur,
                          input int nvs);
    exp_t e;
    n_exp++;
    e.id = n_exp; e.sr = sr; e.lk = lk; e.fe = fe;
    e.ht = ht; e.vt = vt; e.ha = ha; e.rc = rc; e.dur = dur; e.nvs = nvs;
    q.push_back(e);
  endtask

  // Monitor: an event is any change of serdes_rst or locked.
  always @(posedge clk) begin
    rst_edge = !rstn;
    if (vsync && !prev_vs) vs_cnt++;
    prev_vs = vsync;
    #2;
    cyc++;
    if (serdes_rst !== prev_sr || locked !== prev_lk) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event serdes_rst %0b locked %0b at cycle %0d",
                 serdes_rst, locked, cyc);
      end else begin
        m_e = q.pop_front();
        chk(m_e.id, "serdes_rst", int'(serdes_rst), int'(m_e.sr));
        chk(m_e.id, "locked",     int'(locked),     int'(m_e.lk));
        chk(m_e.id, "frame_en",   int'(frame_en),   int'(m_e.fe));
        chk(m_e.id, "h_total",    int'(h_total),    m_e.ht);
        chk(m_e.id, "v_total",    int'(v_total),    m_e.vt);
        chk(m_e.id, "h_active",   int'(h_active),   m_e.ha);
        chk(m_e.id, "retry_cnt",  int'(retry_cnt),  m_e.rc);
        if (m_e.dur >= 0) chk(m_e.id, "cycles_since_prev", cyc - last_cyc, m_e.dur);
        if (m_e.nvs >= 0) chk(m_e.id, "vs_rises_since_sync", vs_cnt - vs_base, m_e.nvs);
      end
      if (prev_sr && !serdes_rst) vs_base = vs_cnt;
      last_cyc = cyc;
    end
    if (rst_edge) last_cyc = cyc;
    prev_sr = serdes_rst;
    prev_lk = locked;
  end

  task automatic line(input int len, input logic vs);
    for (int i = 0; i < len; i++) begin
      hsync = (i < 8);
      de    = (i >= 20) && (i < 820);
      vsync = vs && (i >= 10) && (i < 14);
      @(negedge clk);
    end
  endtask

  task automatic frame(input int nl, input int long_idx, input int long_len);
    for (int l = 0; l < nl; l++) line((l == long_idx) ? long_len : 1056, l == 0);
  endtask

  task automatic idle(input int n);
    hsync = 1'b0; de = 1'b0; vsync = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset, SERDES reset release, clean lock at 1056 x 3.
    push_exp(1, 0, 0, 0, 0, 0, 0, -1, -1);
    push_exp(0, 0, 0, 0, 0, 0, 0, 64, -1);
    push_exp(0, 1, 1, 1056, 3, 800, 0, -1, 6);
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (7) frame(3, -1, 0);

    // 1058-clock line tolerated, 1059-clock line drops lock, then relock.
    push_exp(1, 0, 0, 1056, 3, 800, 1, -1, -1);
    push_exp(0, 0, 0, 1056, 3, 800, 1, 64, -1);
    push_exp(0, 1, 1, 1056, 3, 800, 1, -1, 6);
    frame(3, 1, 1058);
    frame(3, 1, 1059);
    repeat (6) frame(3, -1, 0);

    // Frame height drops to 2 lines: fault at the next vs, relock with v_total=2.
    push_exp(1, 0, 0, 1056, 3, 800, 2, -1, -1);
    push_exp(0, 0, 0, 1056, 3, 800, 2, 64, -1);
    push_exp(0, 1, 1, 1056, 2, 800, 2, -1, 6);
    repeat (8) frame(2, -1, 0);

    // Signal loss: lock edge is 1046 clocks before the last hs edge, fault 4096 after it.
    push_exp(1, 0, 0, 1056, 2, 800, 3, 5142, -1);
    push_exp(0, 0, 0, 1056, 2, 800, 3, 64, -1);
    idle(3060);

    // Reset while training with three consistent frames.
    push_exp(1, 0, 0, 0, 0, 0, 0, -1, -1);
    push_exp(0, 0, 0, 0, 0, 0, 0, 64, -1);
    repeat (4) frame(2, -1, 0);
    line(1056, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    frame(2, -1, 0);
    idle(200);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
